// File: rtl/led_matrix_driver_if.sv
// Pixel-fetch and panel-drive bus of led_matrix_driver.
// The master drives the buffer addresses and panel pins. The slave returns the pixels.
interface led_matrix_driver_if #(
    parameter int ADDR_W = 11,
    parameter int PIX_W  = 6,
    parameter int ROW_W  = 5
);
    logic [ADDR_W-1:0] pixelAddress0;
    logic [ADDR_W-1:0] pixelAddress1;
    logic [PIX_W-1:0]  pixel0;
    logic [PIX_W-1:0]  pixel1;
    logic [ROW_W-1:0]  rowDecoder;
    logic              pixelClk;
    logic [2:0]        columnPixels0;
    logic [2:0]        columnPixels1;
    logic              columnLatch;
    logic              blank;
    logic              done;

    modport master (
        output pixelAddress0, pixelAddress1, rowDecoder, pixelClk,
               columnPixels0, columnPixels1, columnLatch, blank, done,
        input  pixel0, pixel1
    );

    modport slave (
        input  pixelAddress0, pixelAddress1, rowDecoder, pixelClk,
               columnPixels0, columnPixels1, columnLatch, blank, done,
        output pixel0, pixel1
    );
endinterface

// File: rtl/led_matrix_driver.sv
// HUB75-style scan driver: shift, latch and BCM-show each row pair from two half-panel buffers.
// Define LED_MATRIX_BCM_EN for full binary-coded modulation. Without it, only the MSB plane is scanned.
module led_matrix_driver #(
    parameter int COLS      = 64,
    parameter int ROW_PAIRS = 32,
    parameter int BPC       = 2,
    parameter int CLK_DIV   = 4,
    parameter int SHOW_BASE = 8
) (
    input logic                 clkIn,
    input logic                 rst,
    led_matrix_driver_if.master bus
);
    localparam int ROW_W      = $clog2(ROW_PAIRS);
    localparam int ADDR_W     = $clog2(ROW_PAIRS*COLS);
    localparam int PIX_W      = 3*BPC;
    localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PL_W       = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int SHOW_MAX   = SHOW_BASE << (BPC-1);
    localparam int SHOW_W     = $clog2(SHOW_MAX+1);
    localparam int NUM_HALVES = 2;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROW_PAIRS*COLS-1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS-1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROW_PAIRS-1);
    localparam logic [PL_W-1:0]   PL_LAST   = PL_W'(BPC-1);
`ifdef LED_MATRIX_BCM_EN
    localparam logic [PL_W-1:0]   PL_FIRST  = '0;
`else
    localparam logic [PL_W-1:0]   PL_FIRST  = PL_LAST;
`endif

    typedef enum logic [1:0] {SHIFT, LATCH, SHOW} state_t;

    // Tick divider
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(CLK_DIV-1));

    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) div_q <= '0;
        else      div_q <= tick ? '0 : div_q + DIV_W'(1);
    end

    // Scan state
    state_t                         state_q, state_d;
    logic                           phase_q, phase_d;
    logic [COL_W-1:0]               col_q, col_d;
    logic [PL_W-1:0]                plane_q, plane_d, plane_nxt;
    logic [ROW_W-1:0]               row_q, row_d, row_nxt;
    logic [SHOW_W-1:0]              cnt_q, cnt_d, show_len;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [ROW_W-1:0]               rowdec_q, rowdec_d;
    logic                           pclk_q, pclk_d;
    logic                           latch_q, latch_d;
    logic                           blank_q, blank_d;
    logic                           done_q, done_d;
    logic [NUM_HALVES-1:0][2:0]     cp_q, cp_d;

    // Per-half plane select
    logic [NUM_HALVES-1:0][PIX_W-1:0] pix;
    logic [NUM_HALVES-1:0][2:0]       rgb;

    assign pix = {bus.pixel1, bus.pixel0};

    for (genvar h = 0; h < NUM_HALVES; h++) begin : g_half
        logic [BPC-1:0] ch_r, ch_g, ch_b;
        assign {ch_r, ch_g, ch_b} = pix[h];
        assign rgb[h] = {ch_r[plane_q], ch_g[plane_q], ch_b[plane_q]};
    end

`ifdef LED_MATRIX_BCM_EN
    assign show_len = SHOW_W'(SHOW_BASE) << plane_q;
`else
    assign show_len = SHOW_W'(SHOW_BASE);
`endif

    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            state_q  <= SHIFT;
            phase_q  <= 1'b0;
            col_q    <= '0;
            plane_q  <= PL_FIRST;
            row_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            rowdec_q <= '0;
            pclk_q   <= 1'b0;
            latch_q  <= 1'b0;
            blank_q  <= 1'b1;
            done_q   <= 1'b0;
            cp_q     <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            col_q    <= col_d;
            plane_q  <= plane_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rowdec_q <= rowdec_d;
            pclk_q   <= pclk_d;
            latch_q  <= latch_d;
            blank_q  <= blank_d;
            done_q   <= done_d;
            cp_q     <= cp_d;
        end
    end

    // Each tick sets the pin values for the tick slot that follows it.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        col_d     = col_q;
        plane_d   = plane_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rowdec_d  = rowdec_q;
        pclk_d    = pclk_q;
        latch_d   = latch_q;
        blank_d   = blank_q;
        cp_d      = cp_q;
        done_d    = 1'b0;
        plane_nxt = plane_q;
        row_nxt   = row_q;

        if (tick) begin
            unique case (state_q)
                SHIFT: begin
                    blank_d = 1'b1;
                    latch_d = 1'b0;
                    if (!phase_q) begin
                        pclk_d  = 1'b0;
                        cp_d    = rgb;
                        addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
                        phase_d = 1'b1;
                    end else begin
                        pclk_d  = 1'b1;
                        phase_d = 1'b0;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            state_d = LATCH;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                LATCH: begin
                    pclk_d   = 1'b0;
                    latch_d  = 1'b1;
                    blank_d  = 1'b1;
                    rowdec_d = row_q;
                    cnt_d    = '0;
                    state_d  = SHOW;
                end
                SHOW: begin
                    latch_d = 1'b0;
                    blank_d = 1'b0;
                    cnt_d   = cnt_q + SHOW_W'(1);
                    if (cnt_q == show_len - SHOW_W'(1)) begin
                        state_d = SHIFT;
                        if (plane_q == PL_LAST) begin
                            plane_nxt = PL_FIRST;
                            row_nxt   = row_q + ROW_W'(1);
                            done_d    = (row_q == ROW_LAST);
                        end else begin
                            plane_nxt = plane_q + PL_W'(1);
                        end
                        plane_d = plane_nxt;
                        row_d   = row_nxt;
                        addr_d  = ADDR_W'(row_nxt) * ADDR_W'(COLS);
                    end
                end
                default: state_d = SHIFT;
            endcase
        end
    end

    assign bus.pixelAddress0 = addr_q;
    assign bus.pixelAddress1 = addr_q;
    assign bus.rowDecoder    = rowdec_q;
    assign bus.pixelClk      = pclk_q;
    assign bus.columnPixels0 = cp_q[0];
    assign bus.columnPixels1 = cp_q[1];
    assign bus.columnLatch   = latch_q;
    assign bus.blank         = blank_q;
    assign bus.done          = done_q;
endmodule

// File: doc/led_matrix_driver.md
# led_matrix_driver

Parametrised HUB75-style LED matrix scan driver and successor to the fixed-size 6-bit display driver. It fetches pixels from two half-panel frame buffers (top and bottom) and shifts them into the panel column by column. It then latches and shows each row pair, using binary-coded modulation (BCM) over BPC bit-planes per colour channel to produce grey levels. `done` pulses once per frame so the buffer owner can swap buffers.

## Interface
Parameters:
- COLS, 64: panel columns per row.
- ROW_PAIRS, 32: row pairs addressed by rowDecoder; must be a power of 2, ≥2.
- BPC, 2: bits per colour channel, 1..8.
- CLK_DIV, 4: clkIn cycles per internal tick, ≥2.
- SHOW_BASE, 8: ticks the LSB plane is displayed.
- Derived: ROW_W=$clog2(ROW_PAIRS), ADDR_W=$clog2(ROW_PAIRS*COLS), PIX_W=3*BPC.

Ports:
- clkIn  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- pixelAddress0  out  ADDR_W  top-half buffer address = row*COLS+col.
- pixel0  in  PIX_W  top-half pixel {R[BPC-1:0],G[BPC-1:0],B[BPC-1:0]}.
- pixelAddress1  out  ADDR_W  bottom-half address; always equal to pixelAddress0.
- pixel1  in  PIX_W  bottom-half pixel, same format.
- rowDecoder  out  ROW_W  selected row pair.
- pixelClk  out  1  panel shift clock.
- columnPixels0  out  3  {R,G,B} bit, top half.
- columnPixels1  out  3  {R,G,B} bit, bottom half.
- columnLatch  out  1  panel latch strobe.
- blank  out  1  output-enable, active-high blank.
- done  out  1  end-of-frame pulse, 1 clkIn cycle.

## Operation
- Tick generator: divider counts clkIn cycles and raises `tick` for one cycle every CLK_DIV cycles. All other state advances only on tick.
- Counters: col (0..COLS-1), plane b (0..BPC-1), row (0..ROW_PAIRS-1), show counter.
- States:
  - SHIFT: 2 ticks per column, blank=1.
    - Low tick: pixelClk=0. columnPixels0={pixel0[2BPC+b],pixel0[BPC+b],pixel0[b]}, same for columnPixels1 from pixel1. The address then advances to the next column.
    - High tick: pixelClk=1.
    - After the high tick of col COLS-1, go to LATCH.
  - LATCH: 1 tick. columnLatch=1, blank=1, rowDecoder<=row, pixelClk=0.
  - SHOW: blank=0 for SHOW_BASE<<b ticks.
    - On exit, b increments. If b wraps, row increments (wrapping to 0).
    - pixelAddress is set to row*COLS using the new row, then go to SHIFT.
- done=1 for the single clkIn cycle of the tick that exits SHOW for the last plane of row ROW_PAIRS-1.
- Pixel inputs are sampled one full tick (CLK_DIV cycles) after the address changes, so synchronous-read RAM is supported.
- Row/plane order: row-major; planes LSB→MSB within a row.
- Address arithmetic is unsigned, ADDR_W bits; wraps from ROW_PAIRS*COLS-1 to 0 at end of frame.

## Timing
- Reset values:
  - pixelAddress0/1=0, rowDecoder=0, pixelClk=0, columnPixels0/1=0, columnLatch=0, blank=1, done=0.
  - State SHIFT, col=b=row=0, divider=0.
- First tick occurs CLK_DIV clkIn cycles after rst deasserts.
- Ticks per plane = 2*COLS+1+(SHOW_BASE<<b).
- Frame = ROW_PAIRS × Σ planes.
- Reset mid-operation: all outputs return to reset values immediately (async). A partially shifted row is discarded and scanning restarts at row 0, plane 0.
- columnLatch and pixelClk are never high together. blank is never 0 outside SHOW.

## Configuration
- LED_MATRIX_BCM_EN defined: full BCM as above, BPC planes per row.
- Not defined:
  - Only plane b=BPC-1 (MSB) is scanned, giving on/off per channel.
  - SHOW lasts SHOW_BASE ticks.
  - One plane per row; done is asserted on the last row's exit.

## Test plan
Parameters: COLS=4, ROW_PAIRS=2, BPC=2, CLK_DIV=2, SHOW_BASE=3.
- Reset, release -> all outputs at reset values. First pixelClk rise at clkIn cycle 4 after release (tick 2). pixelAddress sequence 0,1,2,3 during row 0.
- BCM_EN, pixel0=6'b11_01_10 constant:
  - Plane 0 shifts columnPixels0=3'b110; plane 1 shifts 3'b101.
  - blank=0 for 3 ticks then 6 ticks.
  - done period = 54 ticks = 108 clkIn cycles.
- Without macro, same stimulus -> only 3'b101 is shifted. blank=0 for 3 ticks per row. done period = 24 ticks = 48 clkIn.
- pixel1 driven as function of address (pixel1=addr[2:0]) -> columnPixels1 reflects the value fetched one tick earlier. 4 pixelClk rises precede each columnLatch. rowDecoder toggles 0→1→0.
- Assert rst during SHOW of row 1 -> blank=1 and rowDecoder=0 within the same cycle. After release, scan restarts at address 0, plane 0.
- Assertions, whole run: columnLatch exactly 1 tick wide. No overlap of columnLatch with pixelClk. blank==0 only in SHOW. done is exactly 1 clkIn cycle wide.
